// File: rtl/rate_meter_pkg.sv
// rtl/rate_meter_pkg.sv - shared types, widths and default window helper for the rate meter
package rate_meter_pkg;

    localparam int RES_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_MEASURE,
        ST_REPORT
    } rm_state_e;

    // One second worth of clock ticks for a clock given in MHz.
    function automatic logic [RES_WIDTH-1:0] default_window(input int unsigned clk_mhz);
        return RES_WIDTH'(clk_mhz * 32'd1000000);
    endfunction

endpackage

// File: rtl/rate_meter_scheduler_if.sv
// rtl/rate_meter_scheduler_if.sv - per-channel result handshake between scheduler and consumer
interface rate_meter_scheduler_if
    import rate_meter_pkg::*;
#(
    parameter int CH_W = 2
);
    logic                 res_valid;
    logic                 res_ready;
    logic [CH_W-1:0]      res_ch;
    logic [RES_WIDTH-1:0] res_count;
    logic                 res_ovf;

    modport master (
        output res_valid,
        output res_ch,
        output res_count,
        output res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_ch,
        input  res_count,
        input  res_ovf,
        output res_ready
    );
endinterface

// File: rtl/rate_gate_counter.sv
// rtl/rate_gate_counter.sv - gated saturating strobe counter with sticky overflow flag
module rate_gate_counter
    import rate_meter_pkg::*;
#(
    // Value loaded on clear; non-zero only to shorten saturation runs in simulation.
    parameter logic [RES_WIDTH-1:0] CLR_VAL = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 inc,
    output logic [RES_WIDTH-1:0] count,
    output logic                 ovf
);

    // Count enabled strobes; an increment attempted at all-ones holds the value and flags overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= CLR_VAL;
            ovf   <= 1'b0;
        end else if (en && inc) begin
            if (count == '1) begin
                ovf <= 1'b1;
            end else begin
                count <= count + RES_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rate_meter_scheduler.sv
// rtl/rate_meter_scheduler.sv - sweeps enabled channels through one shared gated counter
module rate_meter_scheduler
    import rate_meter_pkg::*;
#(
    parameter int                   CH_NUM      = 4,
    parameter int                   CLK_MHZ_VAL = 100,
    parameter logic [RES_WIDTH-1:0] CNT_PRELOAD = '0
) (
    input  logic                   clk_i,
    input  logic                   s_rst_n_i,
    input  logic [CH_NUM-1:0]      data_valid_i,
    input  logic [CH_NUM-1:0]      ch_mask_i,
    input  logic [RES_WIDTH-1:0]   win_ticks_i,
    input  logic                   continuous_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   busy_o,
    rate_meter_scheduler_if.master res_if
);

    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PTR_W = $clog2(CH_NUM + 1);
    localparam logic [RES_WIDTH-1:0] DEF_WIN = default_window(CLK_MHZ_VAL);

    rm_state_e            state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CH_NUM-1:0]    mask_q, mask_d;
    logic [RES_WIDTH-1:0] win_q, win_d;
    logic [RES_WIDTH-1:0] tick_q, tick_d;
    logic                 cont_q, cont_d;
    logic                 stop_pend_q, stop_pend_d;

    logic                 pick_found;
    logic [CH_W-1:0]      pick_ch;
    logic [RES_WIDTH-1:0] win_sel;
    logic                 cnt_clr, cnt_en;
    logic [RES_WIDTH-1:0] cnt_count;
    logic                 cnt_ovf;

    assign win_sel = (win_ticks_i == '0) ? DEF_WIN : win_ticks_i;

    // Lowest enabled channel at or above the sweep pointer (scan downwards so the lowest wins).
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(i);
            end
        end
    end

    // Next-state, configuration latching and counter control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        win_d       = win_q;
        tick_d      = tick_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i && (ch_mask_i != '0)) begin
                    mask_d      = ch_mask_i;
                    win_d       = win_sel;
                    cont_d      = continuous_i;
                    ptr_d       = '0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (pick_found) begin
                    ch_d    = pick_ch;
                    tick_d  = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_MEASURE;
                end else if (cont_q) begin
                    mask_d = ch_mask_i;
                    win_d  = win_sel;
                    ptr_d  = '0;
                    if (ch_mask_i == '0) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    tick_d = tick_q + RES_WIDTH'(1);
                    if (tick_q == win_q - RES_WIDTH'(1)) begin
                        ptr_d   = PTR_W'(ch_q) + PTR_W'(1);
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (res_if.res_ready) begin
                    stop_pend_d = 1'b0;
                    state_d     = (stop_pend_q || stop_i) ? ST_IDLE : ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched configuration registers.
    always_ff @(posedge clk_i) begin
        if (s_rst_n_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            win_q       <= '0;
            tick_q      <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            win_q       <= win_d;
            tick_q      <= tick_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    rate_gate_counter #(
        .CLR_VAL (CNT_PRELOAD)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (s_rst_n_i),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .inc   (data_valid_i[ch_q]),
        .count (cnt_count),
        .ovf   (cnt_ovf)
    );

    // Result fields read as zero outside REPORT so a stale count never leaks out.
    always_comb begin
        busy_o           = (state_q != ST_IDLE);
        res_if.res_valid = (state_q == ST_REPORT);
        res_if.res_ch    = res_if.res_valid ? ch_q : '0;
        res_if.res_count = res_if.res_valid ? cnt_count : '0;
        res_if.res_ovf   = res_if.res_valid & cnt_ovf;
    end

endmodule

// File: tb/tb_rate_meter_scheduler.sv
// tb/tb_rate_meter_scheduler.sv - directed table-driven bench for rate_meter_scheduler
module tb_rate_meter_scheduler;
    import rate_meter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dv;
    logic [3:0]  mask;
    logic [31:0] win;
    logic        cont, start, stop, ready;
    logic        busy, busy_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rate_meter_scheduler_if #(.CH_W(2)) rif ();
    rate_meter_scheduler_if #(.CH_W(2)) sif ();

    assign rif.res_ready = ready;
    assign sif.res_ready = ready;

    rate_meter_scheduler #(.CH_NUM(4), .CLK_MHZ_VAL(100)) dut (
        .clk_i(clk), .s_rst_n_i(rst), .data_valid_i(dv), .ch_mask_i(mask),
        .win_ticks_i(win), .continuous_i(cont), .start_i(start), .stop_i(stop),
        .busy_o(busy), .res_if(rif)
    );

    rate_meter_scheduler #(.CH_NUM(4), .CLK_MHZ_VAL(100), .CNT_PRELOAD(32'hFFFF_FFF0)) dut_sat (
        .clk_i(clk), .s_rst_n_i(rst), .data_valid_i(dv), .ch_mask_i(mask),
        .win_ticks_i(win), .continuous_i(cont), .start_i(start), .stop_i(stop),
        .busy_o(busy_s), .res_if(sif)
    );

    typedef struct {
        logic [3:0]        mask;
        logic [31:0]       win;
        int                n;
        logic [3:0][1:0]   ch;
        logic [3:0][31:0]  cnt;
    } vec_t;

    vec_t vecs[5];

    // Strobe patterns: ch0 every cycle, ch1 every 4th, ch2 every other, ch3 never.
    int unsigned cyc = 0;
    initial begin
        dv = '0;
        forever begin
            @(negedge clk);
            cyc++;
            dv[0] = 1'b1;
            dv[1] = (cyc % 4 == 0);
            dv[2] = cyc[0];
            dv[3] = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] m, input logic [31:0] w, input logic c);
        mask  = m;
        win   = w;
        cont  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!rif.res_valid && k < 300) begin
            tick();
            k++;
        end
        check("valid_seen", 64'(rif.res_valid), 64'd1);
    endtask

    task automatic set_vec(input int idx, input logic [3:0] m, input logic [31:0] w, input int n,
                           input logic [1:0] c0, input logic [31:0] n0,
                           input logic [1:0] c1, input logic [31:0] n1,
                           input logic [1:0] c2, input logic [31:0] n2,
                           input logic [1:0] c3, input logic [31:0] n3);
        vecs[idx].mask = m;
        vecs[idx].win  = w;
        vecs[idx].n    = n;
        vecs[idx].ch   = {c3, c2, c1, c0};
        vecs[idx].cnt  = {n3, n2, n1, n0};
    endtask

    initial begin
        int k;
        int seen;

        set_vec(0, 4'b0101, 32'd10, 2, 2'd0, 32'd10, 2'd2, 32'd5, 2'd0, 32'd0, 2'd0, 32'd0);
        set_vec(1, 4'b0010, 32'd8,  1, 2'd1, 32'd2,  2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
        set_vec(2, 4'b1000, 32'd6,  1, 2'd3, 32'd0,  2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
        set_vec(3, 4'b1111, 32'd4,  4, 2'd0, 32'd4,  2'd1, 32'd1, 2'd2, 32'd2, 2'd3, 32'd0);
        set_vec(4, 4'b0001, 32'd1,  1, 2'd0, 32'd1,  2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);

        rst = 1'b1; mask = '0; win = '0; cont = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {busy, rif.res_valid, rif.res_ovf, rif.res_ch, rif.res_count}, 64'd0);
        rst = 1'b0;
        tick();

        // Single-shot sweeps with ready tied high.
        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].mask, vecs[v].win, 1'b0);
            check("busy_rise", 64'(busy), 64'd1);
            for (int r = 0; r < vecs[v].n; r++) begin
                wait_valid(k);
                check("latency", 64'(k), 64'(vecs[v].win + 32'd1));
                check("res_ch", 64'(rif.res_ch), 64'(vecs[v].ch[r]));
                check("res_count", 64'(rif.res_count), 64'(vecs[v].cnt[r]));
                check("res_ovf", 64'(rif.res_ovf), 64'd0);
                tick();
                check("valid_drop", 64'(rif.res_valid), 64'd0);
            end
            tick();
            check("sweep_idle", 64'(busy), 64'd0);
        end

        // Saturation, using the preloaded instance alongside the normal one.
        do_start(4'b0001, 32'd20, 1'b0);
        wait_valid(k);
        check("sat_count", 64'(sif.res_count), 64'hFFFF_FFFF);
        check("sat_ovf", 64'(sif.res_ovf), 64'd1);
        check("sat_busy", 64'(busy_s), 64'd1);
        check("nosat_count", 64'(rif.res_count), 64'd20);
        check("nosat_ovf", 64'(rif.res_ovf), 64'd0);
        repeat (2) tick();
        check("sat_idle", 64'(busy), 64'd0);

        // Backpressure: seven stalled cycles in REPORT.
        ready = 1'b0;
        do_start(4'b0011, 32'd5, 1'b0);
        wait_valid(k);
        check("bp_latency", 64'(k), 64'd6);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_stable", {rif.res_valid, rif.res_ch, rif.res_count}, {1'b1, 2'd0, 32'd5});
        end
        ready = 1'b1;
        tick();
        check("bp_drop", {busy, rif.res_valid}, {1'b1, 1'b0});
        wait_valid(k);
        check("bp_next_latency", 64'(k), 64'd6);
        check("bp_next_ch", 64'(rif.res_ch), 64'd1);
        repeat (2) tick();
        check("bp_idle", 64'(busy), 64'd0);

        // Stop in MEASURE on ch1: result discarded.
        do_start(4'b0010, 32'd20, 1'b0);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_meas_idle", {busy, rif.res_valid}, 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rif.res_valid || busy) seen++;
        end
        check("stop_meas_quiet", 64'(seen), 64'd0);

        // Stop in REPORT: handshake still completes, then IDLE.
        ready = 1'b0;
        do_start(4'b0011, 32'd4, 1'b0);
        wait_valid(k);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_rep_hold", {rif.res_valid, rif.res_ch, rif.res_count}, {1'b1, 2'd0, 32'd4});
        ready = 1'b1;
        tick();
        check("stop_rep_idle", {busy, rif.res_valid}, 64'd0);

        // Continuous: mask change takes effect only at the next sweep.
        do_start(4'b0011, 32'd4, 1'b1);
        mask = 4'b1000;
        for (int r = 0; r < 4; r++) begin
            wait_valid(k);
            check("cont_ch", 64'(rif.res_ch), (r == 0) ? 64'd0 : (r == 1) ? 64'd1 : 64'd3);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_idle", 64'(busy), 64'd0);

        // Reset during MEASURE.
        do_start(4'b0001, 32'd10, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_meas", {busy, rif.res_valid, rif.res_ovf, rif.res_ch, rif.res_count}, 64'd0);
        rst = 1'b0;
        tick();

        // Reset during REPORT.
        ready = 1'b0;
        do_start(4'b0001, 32'd3, 1'b0);
        wait_valid(k);
        rst = 1'b1;
        tick();
        check("rst_rep", {busy, rif.res_valid, rif.res_ovf, rif.res_ch, rif.res_count}, 64'd0);
        rst = 1'b0;
        ready = 1'b1;
        tick();

        // Zero mask start is ignored.
        do_start(4'b0000, 32'd5, 1'b0);
        check("zero_mask_idle", 64'(busy), 64'd0);
        repeat (2) tick();
        check("zero_mask_idle_later", 64'(busy), 64'd0);

        // Start with stop in the same cycle: stop wins.
        mask = 4'b0001; win = 32'd5; stop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 64'(busy), 64'd0);
        tick();
        check("start_stop_idle_later", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rate_meter_scheduler.md
# rate_meter_scheduler

Measurement controller that time-shares one gated bit counter across `CH_NUM` data-valid streams. Sweeps the enabled channels in ascending order, counts each for a programmable window of clock ticks, and presents per-channel results over a valid/ready handshake. It sequences rate measurement in the monitoring path and supports single-shot and continuous operation.

## Interface
- `CH_NUM`, 4: number of monitored channels, 1..16.
- `CLK_MHZ_VAL`, 100: clock frequency in MHz; `win_ticks_i == 0` selects a window of `CLK_MHZ_VAL*1000000` ticks, i.e. 1 s.
- `RES_WIDTH`, 32: fixed width of counts and window (package constant, not overridable).

- `clk_i` in 1: single clock.
- `s_rst_n_i` in 1: reset. Synchronous, active-high: asserted when 1.
- `data_valid_i` in `CH_NUM`: per-channel bit strobes, one bit per cycle when high.
- `ch_mask_i` in `CH_NUM`: channels to include in a sweep.
- `win_ticks_i` in 32: window length in cycles; 0 selects the default 1 s window.
- `continuous_i` in 1: 1 repeats sweeps, 0 performs one sweep.
- `start_i` in 1: start pulse; honoured only in IDLE.
- `stop_i` in 1: stop request.
- `busy_o` out 1: high whenever the state is not IDLE.
- `res_valid_o` out 1: result available.
- `res_ready_i` in 1: result consumed.
- `res_ch_o` out `$clog2(CH_NUM)` (min 1): channel index of the result.
- `res_count_o` out 32: count of strobes in the window.
- `res_ovf_o` out 1: the count saturated.

## Operation
- States are IDLE, SELECT, MEASURE, REPORT.
- **IDLE**
  - `start_i=1`, `stop_i=0` and `ch_mask_i!=0`: latch mask, window, mode and pointer=0, then go to SELECT.
  - `start_i` with a zero mask is ignored.
- **SELECT**
  - Pick the lowest enabled channel with index ≥ pointer, then go to MEASURE.
  - If none remain, the sweep is over:
    - continuous: re-latch `ch_mask_i` and `win_ticks_i`, set pointer=0, stay in SELECT. A re-latched zero mask goes to IDLE.
    - single-shot: go to IDLE.
- **MEASURE**
  - The counter clears on entry.
  - It increments on each cycle where `data_valid_i[ch]=1`, for exactly W cycles.
  - It saturates at 0xFFFF_FFFF and sets the overflow flag.
  - Then go to REPORT, with pointer = ch+1.
- **REPORT**
  - Hold `res_*` outputs.
  - On `res_valid_o && res_ready_i`, go to SELECT, or to IDLE if a stop is pending.
- **stop_i behaviour**
  - In MEASURE: abort, discard the result, go to IDLE.
  - In SELECT: go to IDLE.
  - In REPORT: set stop-pending and finish the handshake.
- `start_i` outside IDLE is ignored. When `start_i` and `stop_i` arrive together in IDLE, stop wins.
- `data_valid_i` of non-selected channels is ignored.

## Timing
- Every output resets to 0 one cycle after `s_rst_n_i=1` is sampled, from any state. An in-flight result is lost.
- Sequence for a start in cycle N:
  - N+1: SELECT.
  - N+2 … N+1+W: MEASURE, with `data_valid_i` sampled in exactly these W cycles.
  - N+2+W: REPORT with `res_valid_o=1`.
- Handshake:
  - `res_*` stay stable while `res_valid_o && !res_ready_i`.
  - `res_valid_o` drops the cycle after acceptance.
  - The next SELECT follows that acceptance.
- Per-channel period is W+2 cycles plus any ready stall. There is no counting during SELECT or REPORT.
- `busy_o` rises in cycle N+1.
- `res_ovf_o=1` implies `res_count_o=0xFFFF_FFFF`.

## Structure
- Package `rate_meter_pkg` holds:
  - the state enum `rm_state_e`;
  - `RES_WIDTH=32`;
  - the function that computes the default window from `CLK_MHZ_VAL`.
- Sub-module `rate_gate_counter`:
  - a gated, saturating 32-bit counter with `clr`, `en` and `inc` inputs and `count`/`ovf` outputs;
  - instantiated once.
- The scheduler holds the FSM, the window tick counter, the channel pointer/priority pick, and the latched configuration.

## Test plan
- **Single-shot, all channels:** mask=4'b0101, W=10, ch0 strobing every cycle, ch2 every other cycle, ready tied 1 → results (0,10) then (2,5), then IDLE with `busy_o=0`.
- **Backpressure:** hold `res_ready_i=0` for 7 cycles in REPORT → outputs stable and no counting; the next MEASURE starts 1 cycle after acceptance.
- **Saturation:** force the counter near the limit (W=0xFFFF_FFF0 in a shortened sim with preloaded count, or CLK_MHZ_VAL scaled) → count=0xFFFF_FFFF, `res_ovf_o=1`.
- **Stop:**
  - mid-MEASURE on ch1 → no result, IDLE next cycle;
  - in REPORT → result still delivered, then IDLE.
- **Continuous mode:** mask changes from 4'b0011 to 4'b1000 mid-sweep → the current sweep finishes on ch0 and ch1, and the next sweep measures ch3 only.
- **Reset and zero cases:**
  - reset asserted in MEASURE and REPORT → all outputs 0 next cycle;
  - `start_i` with mask=0 → stays IDLE;
  - `start_i` and `stop_i` together → stays IDLE.
